// File: rtl/start_sequencer.sv
// Start-button sequencer: synchronises the button and switches, debounces the
// button, then issues one start pulse per press and supervises core completion.
module start_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_btnRaw,
    input  logic [3:0] io_digitSelRaw,
    input  logic [3:0] io_imgSelRaw,
    input  logic       io_done,
    output logic       io_start,
    output logic [3:0] io_digitSel,
    output logic [3:0] io_imgSel,
    output logic       io_busy,
    output logic       io_timeout
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

    logic [SYNC_STAGES-1:0]      btn_sync;
    logic [SYNC_STAGES-1:0][3:0] digit_sync;
    logic [SYNC_STAGES-1:0][3:0] img_sync;
    logic                        btn_s;
    logic [3:0]                  digit_s;
    logic [3:0]                  img_s;

    logic           db_level;
    logic           db_prev;
    logic [DCW-1:0] db_cnt;
    logic           press;

    logic           done_prev;
    logic           done_rise;

    state_t         state, state_next;
    logic [TCW-1:0] tcnt, tcnt_next;
    logic [3:0]     digit_next, img_next;
    logic           timeout_next;

    assign btn_s   = btn_sync[SYNC_STAGES-1];
    assign digit_s = digit_sync[SYNC_STAGES-1];
    assign img_s   = img_sync[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_sync   <= '0;
            digit_sync <= '0;
            img_sync   <= '0;
        end else begin
            btn_sync   <= {btn_sync[SYNC_STAGES-2:0], io_btnRaw};
            digit_sync <= {digit_sync[SYNC_STAGES-2:0], io_digitSelRaw};
            img_sync   <= {img_sync[SYNC_STAGES-2:0], io_imgSelRaw};
        end
    end

    // Level changes only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            db_prev <= db_level;
            if (btn_s != db_level) begin
                if (db_cnt == DCW'(DEBOUNCE_CYCLES - 1)) begin
                    db_level <= btn_s;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + DCW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign press = db_level & ~db_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) done_prev <= 1'b0;
        else       done_prev <= io_done;
    end

    // Edge, not level: a done left high by the previous run must not end this one.
    assign done_rise = io_done & ~done_prev;

    always_comb begin
        state_next   = state;
        tcnt_next    = tcnt;
        digit_next   = io_digitSel;
        img_next     = io_imgSel;
        timeout_next = io_timeout;
        case (state)
            IDLE: begin
                if (press) begin
                    state_next   = START;
                    digit_next   = digit_s;
                    img_next     = img_s;
                    timeout_next = 1'b0;
                end
            end
            START: begin
                state_next = WAIT_DONE;
                tcnt_next  = '0;
            end
            WAIT_DONE: begin
                if (done_rise) begin
                    state_next = IDLE;
                end else if (tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end else begin
                    tcnt_next = tcnt + TCW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they align with state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tcnt        <= '0;
            io_start    <= 1'b0;
            io_busy     <= 1'b0;
            io_timeout  <= 1'b0;
            io_digitSel <= '0;
            io_imgSel   <= '0;
        end else begin
            state       <= state_next;
            tcnt        <= tcnt_next;
            io_start    <= (state_next == START);
            io_busy     <= (state_next != IDLE);
            io_timeout  <= timeout_next;
            io_digitSel <= digit_next;
            io_imgSel   <= img_next;
        end
    end

endmodule

// File: tb/tb_start_sequencer.sv
// Directed bench for start_sequencer with short debounce/timeout settings.
module tb_start_sequencer;

    logic       clock;
    logic       reset;
    logic       io_btnRaw;
    logic [3:0] io_digitSelRaw;
    logic [3:0] io_imgSelRaw;
    logic       io_done;
    logic       io_start;
    logic [3:0] io_digitSel;
    logic [3:0] io_imgSel;
    logic       io_busy;
    logic       io_timeout;

    int errors = 0;
    int checks = 0;

    start_sequencer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_btnRaw     (io_btnRaw),
        .io_digitSelRaw(io_digitSelRaw),
        .io_imgSelRaw  (io_imgSelRaw),
        .io_done       (io_done),
        .io_start      (io_start),
        .io_digitSel   (io_digitSel),
        .io_imgSel     (io_imgSel),
        .io_busy       (io_busy),
        .io_timeout    (io_timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic release_btn();
        io_btnRaw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if ({io_start, io_busy, io_timeout, io_digitSel, io_imgSel} !== 11'd0) begin
            errors++;
            $display("FAIL reset_hold: got %b expected all zero",
                     {io_start, io_busy, io_timeout, io_digitSel, io_imgSel});
        end
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({io_start, io_busy, io_timeout, io_digitSel, io_imgSel} !== 11'd0) begin
            errors++;
            $display("FAIL reset_idle: got %b expected all zero",
                     {io_start, io_busy, io_timeout, io_digitSel, io_imgSel});
        end
    endtask

    task automatic test_clean_press();
        logic [1:0] exp;
        io_digitSelRaw = 4'd5;
        io_imgSelRaw   = 4'd9;
        io_btnRaw      = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = {1'(i == 7), 1'(i >= 7)};
            checks++;
            if ({io_start, io_busy} !== exp) begin
                errors++;
                $display("FAIL clean_start edge %0d: start/busy got %b expected %b",
                         i, {io_start, io_busy}, exp);
            end
        end
        checks++;
        if (io_digitSel !== 4'd5 || io_imgSel !== 4'd9) begin
            errors++;
            $display("FAIL clean_latch: got digit %0d img %0d expected 5 9",
                     io_digitSel, io_imgSel);
        end
        tick();
        checks++;
        if (io_busy !== 1'b1) begin
            errors++;
            $display("FAIL clean_busy_wait: got %b expected 1", io_busy);
        end
        io_done = 1'b1;
        tick();
        checks++;
        if (io_busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_done: busy got %b expected 0", io_busy);
        end
        io_done = 1'b0;
        release_btn();
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        int pulses;
        pat    = 8'b0111_0111;  // bit i drives cycle i: high 3, low 1, twice
        pulses = 0;
        for (int i = 0; i < 22; i++) begin
            io_btnRaw = (i < 8) ? pat[i] : 1'b1;
            tick();
            if (io_start === 1'b1) pulses++;
            checks++;
            if (io_start !== 1'(i == 14)) begin
                errors++;
                $display("FAIL bounce_start cycle %0d: got %b expected %b",
                         i, io_start, 1'(i == 14));
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL bounce_pulses: got %0d expected 1", pulses);
        end
        io_done = 1'b1;
        tick();
        io_done = 1'b0;
        release_btn();
    endtask

    task automatic test_busy_lockout();
        int pulses;
        pulses         = 0;
        io_digitSelRaw = 4'd5;
        io_imgSelRaw   = 4'd9;
        io_btnRaw      = 1'b1;
        repeat (7) tick();
        checks++;
        if (io_start !== 1'b1) begin
            errors++;
            $display("FAIL lockout_first_start: got %b expected 1", io_start);
        end
        io_btnRaw = 1'b0;
        repeat (6) tick();
        io_btnRaw      = 1'b1;
        io_digitSelRaw = 4'd2;
        io_imgSelRaw   = 4'd3;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (io_start === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || io_busy !== 1'b1) begin
            errors++;
            $display("FAIL lockout_busy_press: pulses %0d busy %b expected 0 1",
                     pulses, io_busy);
        end
        checks++;
        if (io_digitSel !== 4'd5 || io_imgSel !== 4'd9) begin
            errors++;
            $display("FAIL lockout_latch: got digit %0d img %0d expected 5 9",
                     io_digitSel, io_imgSel);
        end
        io_done = 1'b1;
        tick();
        io_done = 1'b0;
        checks++;
        if (io_busy !== 1'b0) begin
            errors++;
            $display("FAIL lockout_done: busy got %b expected 0", io_busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (io_start === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL lockout_not_queued: pulses got %0d expected 0", pulses);
        end
        release_btn();
    endtask

    task automatic test_timeout();
        io_digitSelRaw = 4'd1;
        io_imgSelRaw   = 4'd2;
        io_btnRaw      = 1'b1;
        repeat (7) tick();
        checks++;
        if (io_start !== 1'b1) begin
            errors++;
            $display("FAIL timeout_start: got %b expected 1", io_start);
        end
        repeat (16) tick();
        checks++;
        if ({io_busy, io_timeout} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_before: busy/timeout got %b expected 10",
                     {io_busy, io_timeout});
        end
        tick();
        checks++;
        if ({io_busy, io_timeout} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_expire: busy/timeout got %b expected 01",
                     {io_busy, io_timeout});
        end
        release_btn();
        checks++;
        if (io_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b expected 1", io_timeout);
        end
        io_btnRaw = 1'b1;
        repeat (7) tick();
        checks++;
        if ({io_start, io_timeout} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_clear: start/timeout got %b expected 10",
                     {io_start, io_timeout});
        end
        // Completion arrives on the very cycle the count expires.
        repeat (16) tick();
        io_done = 1'b1;
        tick();
        io_done = 1'b0;
        checks++;
        if ({io_busy, io_timeout} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_tie: busy/timeout got %b expected 00",
                     {io_busy, io_timeout});
        end
        release_btn();
    endtask

    task automatic test_stale_done();
        io_done   = 1'b1;
        io_btnRaw = 1'b1;
        repeat (7) tick();
        checks++;
        if (io_start !== 1'b1) begin
            errors++;
            $display("FAIL stale_start: got %b expected 1", io_start);
        end
        repeat (5) tick();
        checks++;
        if (io_busy !== 1'b1) begin
            errors++;
            $display("FAIL stale_held: busy got %b expected 1", io_busy);
        end
        io_done = 1'b0;
        repeat (2) tick();
        checks++;
        if (io_busy !== 1'b1) begin
            errors++;
            $display("FAIL stale_low: busy got %b expected 1", io_busy);
        end
        io_done = 1'b1;
        tick();
        io_done = 1'b0;
        checks++;
        if (io_busy !== 1'b0) begin
            errors++;
            $display("FAIL stale_rise: busy got %b expected 0", io_busy);
        end
        release_btn();
    endtask

    task automatic test_reset_mid_run();
        io_digitSelRaw = 4'd5;
        io_imgSelRaw   = 4'd9;
        io_btnRaw      = 1'b1;
        repeat (9) tick();
        checks++;
        if (io_busy !== 1'b1 || io_digitSel !== 4'd5) begin
            errors++;
            $display("FAIL midrun_setup: busy %b digit %0d expected 1 5",
                     io_busy, io_digitSel);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({io_start, io_busy, io_timeout, io_digitSel, io_imgSel} !== 11'd0) begin
            errors++;
            $display("FAIL midrun_async: got %b expected all zero",
                     {io_start, io_busy, io_timeout, io_digitSel, io_imgSel});
        end
        repeat (3) tick();
        reset = 1'b0;
        // Button still held: it must count as exactly one fresh press.
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (io_start !== 1'(i == 7)) begin
                errors++;
                $display("FAIL held_after_reset edge %0d: got %b expected %b",
                         i, io_start, 1'(i == 7));
            end
        end
        checks++;
        if (io_digitSel !== 4'd5 || io_imgSel !== 4'd9) begin
            errors++;
            $display("FAIL held_latch: got digit %0d img %0d expected 5 9",
                     io_digitSel, io_imgSel);
        end
        repeat (14) tick();
        checks++;
        if (io_timeout !== 1'b1) begin
            errors++;
            $display("FAIL held_timeout: got %b expected 1", io_timeout);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({io_timeout, io_busy, io_digitSel} !== 6'd0) begin
            errors++;
            $display("FAIL reset_clears_timeout: got %b expected zero",
                     {io_timeout, io_busy, io_digitSel});
        end
        tick();
        io_btnRaw = 1'b0;
        reset     = 1'b0;
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        io_btnRaw      = 1'b0;
        io_digitSelRaw = 4'd0;
        io_imgSelRaw   = 4'd0;
        io_done        = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_busy_lockout();
        test_timeout();
        test_stale_done();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        if (errors == 0) $display("PASS");
        else             $display("FAIL");
        $finish;
    end

endmodule

// File: doc/start_sequencer.md
START_SEQUENCER -- requirements
Module: start_sequencer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser depth for all raw inputs (minimum 2).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the consecutive stable cycles required to accept a button level change.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 100000000, meaning the maximum cycles to wait for core completion.
REQ-004 The block SHALL have port clock  input  1  meaning the single system clock; all state is clocked on its rising edge.
REQ-005 The block SHALL have port reset  input  1  meaning the asynchronous, active-high reset.
REQ-006 The block SHALL have port io_btnRaw  input  1  meaning the raw, asynchronous start push-button.
REQ-007 The block SHALL have ports io_digitSelRaw and io_imgSelRaw  input  4 each  meaning the raw slide-switch selections.
REQ-008 The block SHALL have port io_done  input  1  meaning the core-completion level driven by the processing core.
REQ-009 The block SHALL have port io_start  output  1  meaning the single-cycle start pulse to the core.
REQ-010 The block SHALL have ports io_digitSel and io_imgSel  output  4 each  meaning the selections latched for the current run.
REQ-011 The block SHALL have port io_busy  output  1  meaning a run is in progress.
REQ-012 The block SHALL have port io_timeout  output  1  meaning a sticky flag that the last run timed out.

Function
REQ-013 All raw inputs SHALL pass through SYNC_STAGES flip-flops; the switches SHALL be synchronised only, not debounced.
REQ-014 The debouncer SHALL count each cycle on which the synchronised button differs from the debounced level, clear the count when they match, and on the cycle the count equals DEBOUNCE_CYCLES-1 SHALL update the debounced level and clear the count.
REQ-015 A press SHALL be the rising edge of the debounced level (current=1, previous=0).
REQ-016 The FSM SHALL have states IDLE, START, and WAIT_DONE, and all outputs SHALL be registered.
REQ-017 In IDLE, a press SHALL move the FSM to START, latch the synchronised switches into io_digitSel and io_imgSel, and clear io_timeout.
REQ-018 START SHALL last exactly one cycle with io_start=1 and SHALL then move to WAIT_DONE.
REQ-019 Completion in WAIT_DONE SHALL be a rising edge of io_done (registered previous value); a level held high from an earlier run SHALL NOT complete the run.
REQ-020 On completion the FSM SHALL return to IDLE.
REQ-021 The timeout counter SHALL clear on entry to WAIT_DONE and increment each WAIT_DONE cycle; on the count reaching TIMEOUT_CYCLES-1 without completion, io_timeout SHALL be set and the FSM SHALL return to IDLE.
REQ-022 If completion and timeout occur in the same cycle, completion SHALL win and io_timeout SHALL stay 0.
REQ-023 io_busy SHALL be 1 in START and WAIT_DONE and 0 in IDLE.
REQ-024 Presses while busy SHALL be ignored and not queued.
REQ-025 Switch changes while busy SHALL NOT alter io_digitSel or io_imgSel.
REQ-026 With raw button held stable high, io_start SHALL rise SYNC_STAGES+DEBOUNCE_CYCLES+1 clock edges after the first edge that samples it high.
REQ-027 Button glitches shorter than DEBOUNCE_CYCLES SHALL produce no press.

Reset
REQ-028 Asserting reset at any time, including mid-run, SHALL immediately force: state IDLE, io_start=0, io_busy=0, io_timeout=0, io_digitSel=0, io_imgSel=0, synchronisers, debounced level and all counters 0.
REQ-029 After reset release, a button already held high SHALL register as one press once debounced.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16, SYNC_STAGES=2)
REQ-030 Clean press: switches digit=5, img=9; btn high held -> io_start high exactly 1 cycle at edge 7 after first sample; io_digitSel=5, io_imgSel=9; io_busy=1 until io_done rises, then 0.
REQ-031 Bounce: btn toggled high 3 cycles/low 1 cycle twice, then high -> exactly one io_start; no pulse during the bounce.
REQ-032 Busy lockout: second press and switch change to digit=2 during WAIT_DONE -> no second io_start; io_digitSel stays 5.
REQ-033 Timeout: press with io_done held 0 -> io_timeout=1 and io_busy=0 after 16 WAIT_DONE cycles; the next press -> io_timeout=0.
REQ-034 Stale done: io_done held 1 across a new press -> FSM stays in WAIT_DONE until io_done falls and rises again.
REQ-035 Reset mid-run: reset asserted in WAIT_DONE -> all outputs 0 asynchronously, before the next clock edge.
